// File: rtl/up_sync_counter_pkg.sv
// up_sync_counter_pkg: shared constants and helpers for the synchronous counter family
package up_sync_counter_pkg;
  localparam int MAX_WIDTH = 16;
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction
endpackage

// File: rtl/up_sync_counter_if.sv
// up_sync_counter_if: control and status bundle between a counter and its user
interface up_sync_counter_if #(parameter int WIDTH = 4);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count_out;
  logic             tc;
  logic             wrapped;
  modport master(output en, load, load_val, input count_out, tc, wrapped);
  modport slave(input en, load, load_val, output count_out, tc, wrapped);
endinterface

// File: rtl/up_sync_counter_tff_cell.sv
// up_sync_counter_tff_cell: one counter bit as a T flip-flop with async clear and sync load
module up_sync_counter_tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic i_ld,
  input  logic i_d,
  input  logic i_t,
  output logic o_q
);
  // load beats toggle; reset clears without waiting for the clock
  always_ff @(posedge clk or posedge reset)
    if (reset) o_q <= 1'b0;
    else if (i_ld) o_q <= i_d;
    else if (i_t) o_q <= ~o_q;
endmodule

// File: rtl/up_sync_counter.sv
// up_sync_counter: modulo-N synchronous up-counter with load, terminal count and wrap pulse
module up_sync_counter
  import up_sync_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input logic           clk,
  input logic           reset,
  up_sync_counter_if.slave s
);
  localparam bit               NATURAL = is_pow2(MODULUS) && (MODULUS == (1 << WIDTH));
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  if (WIDTH < 1 || WIDTH > MAX_WIDTH || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
    $error("up_sync_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
  end
  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_d;
  logic             w_at_last;
  logic             w_ld;
  logic             w_load_ok;
  logic             r_wrapped;
  // a short modulus clears at its last value by reusing the load path with d=0
  always_comb begin
    w_at_last = w_count == LAST;
    w_load_ok = {1'b0, s.load_val} < MOD_EXT;
    w_ld      = s.load | (s.en & w_at_last & !NATURAL);
    w_d       = (s.load & w_load_ok) ? s.load_val : '0;
  end
  // bit i toggles only when every lower bit is 1 and counting is enabled
  always_comb begin
    w_t    = '0;
    w_t[0] = s.en;
    for (int i = 1; i < WIDTH; i++) w_t[i] = w_t[i-1] & w_count[i-1];
  end
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    up_sync_counter_tff_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .i_ld (w_ld),
      .i_d  (w_d[b]),
      .i_t  (w_t[b]),
      .o_q  (w_count[b])
    );
  end
  // one-cycle pulse after a counting wrap; loads never raise it
  always_ff @(posedge clk or posedge reset)
    if (reset) r_wrapped <= 1'b0;
    else r_wrapped <= !s.load & s.en & w_at_last;
  assign s.count_out = w_count;
  assign s.tc        = s.en & w_at_last;
  assign s.wrapped   = r_wrapped;
endmodule

// File: tb/tb_up_sync_counter.sv
// tb_up_sync_counter: scoreboard bench for mod-16, mod-10 and cascaded counters
module tb_up_sync_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  up_sync_counter_if #(4) a_if ();
  up_sync_counter_if #(4) b_if ();
  up_sync_counter_if #(4) lo_if ();
  up_sync_counter_if #(4) hi_if ();
  up_sync_counter #(.WIDTH(4), .MODULUS(16)) u_a  (.clk(clk), .reset(reset), .s(a_if.slave));
  up_sync_counter #(.WIDTH(4), .MODULUS(10)) u_b  (.clk(clk), .reset(reset), .s(b_if.slave));
  up_sync_counter #(.WIDTH(4), .MODULUS(16)) u_lo (.clk(clk), .reset(reset), .s(lo_if.slave));
  up_sync_counter #(.WIDTH(4), .MODULUS(16)) u_hi (.clk(clk), .reset(reset), .s(hi_if.slave));
  assign hi_if.en       = lo_if.tc;
  assign hi_if.load     = 1'b0;
  assign hi_if.load_val = 4'd0;
  typedef struct {
    int         sel;
    string      nm;
    logic [7:0] c;
    logic       t;
    logic       w;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // monitor: every queued expectation is compared at the falling edge
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] c;
    logic       t, w;
    if (q.size() > 0) begin
      e = q.pop_front();
      c = e.sel == 0 ? {4'd0, a_if.count_out} : e.sel == 1 ? {4'd0, b_if.count_out} : {hi_if.count_out, lo_if.count_out};
      t = e.sel == 0 ? a_if.tc : e.sel == 1 ? b_if.tc : hi_if.tc;
      w = e.sel == 0 ? a_if.wrapped : e.sel == 1 ? b_if.wrapped : hi_if.wrapped;
      chk({e.nm, ".count"}, c, e.c);
      chk({e.nm, ".tc"}, {7'd0, t}, {7'd0, e.t});
      chk({e.nm, ".wrapped"}, {7'd0, w}, {7'd0, e.w});
    end
  end
  task automatic cyc(input int sel, input logic r, input logic e, input logic l, input logic [3:0] lv,
                     input logic [7:0] ec, input logic et, input logic ew, input string nm);
    @(posedge clk);
    #1;
    reset = r;
    if (sel == 0) begin a_if.en = e; a_if.load = l; a_if.load_val = lv; end
    else if (sel == 1) begin b_if.en = e; b_if.load = l; b_if.load_val = lv; end
    else begin lo_if.en = e; lo_if.load = l; lo_if.load_val = lv; end
    q.push_back('{sel: sel, nm: nm, c: ec, t: et, w: ew});
  endtask
  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    a_if.en = 0; a_if.load = 0; a_if.load_val = 0;
    b_if.en = 0; b_if.load = 0; b_if.load_val = 0;
    lo_if.en = 0; lo_if.load = 0; lo_if.load_val = 0;
    for (int i = 0; i < 18; i++) cyc(0, 1, 1, 0, 0, 8'd0, 0, 0, "rst_a");
    cyc(1, 1, 0, 0, 0, 8'd0, 0, 0, "rst_b");
    cyc(2, 1, 0, 0, 0, 8'd0, 0, 0, "rst_cas");
    for (int k = 0; k <= 20; k++) cyc(0, 0, 1, 0, 0, 8'(k % 16), (k % 16) == 15, k == 16, "t1_count");
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 8'd5, 0, 0, "t2_hold");
    cyc(0, 0, 1, 0, 0, 8'd5, 0, 0, "t2_en");
    cyc(0, 0, 1, 0, 0, 8'd6, 0, 0, "t2_resume");
    cyc(0, 0, 1, 1, 4'd3, 8'd7, 0, 0, "t3_pre");
    cyc(0, 0, 1, 1, 4'd9, 8'd3, 0, 0, "t3_at3");
    cyc(0, 0, 1, 0, 0, 8'd9, 0, 0, "t3_loaded");
    cyc(0, 0, 1, 1, 4'd15, 8'd10, 0, 0, "t3_next");
    cyc(0, 0, 1, 1, 4'd2, 8'd15, 1, 0, "t3_ld15");
    cyc(0, 0, 0, 0, 0, 8'd2, 0, 0, "t3_ldwins");
    for (int k = 0; k <= 12; k++) cyc(1, 0, 1, k == 12, 4'd12, 8'(k % 10), (k % 10) == 9, k == 10, "t4_mod10");
    cyc(1, 0, 0, 1, 4'd9, 8'd0, 0, 0, "t4_ld12");
    cyc(1, 0, 1, 0, 0, 8'd9, 1, 0, "t4_ld9");
    cyc(1, 0, 0, 0, 0, 8'd0, 0, 1, "t4_wrap");
    cyc(1, 0, 0, 0, 0, 8'd0, 0, 0, "t4_idle");
    for (int k = 0; k <= 257; k++) cyc(2, 0, 1, 0, 0, 8'(k), (k % 256) == 255, k == 256, "t6_cascade");
    cyc(2, 0, 0, 0, 0, 8'd2, 0, 0, "t6_stop");
    cyc(0, 0, 0, 1, 4'd7, 8'd2, 0, 0, "t5_pre");
    cyc(0, 0, 0, 0, 0, 8'd7, 0, 0, "t5_at7");
    @(posedge clk);
    #3;
    reset = 1'b1;
    q.push_back('{sel: 0, nm: "t5_async", c: 8'd0, t: 1'b0, w: 1'b0});
    cyc(0, 1, 1, 1, 4'd5, 8'd0, 0, 0, "t5_hold1");
    cyc(0, 1, 1, 1, 4'd5, 8'd0, 0, 0, "t5_hold2");
    cyc(0, 0, 0, 0, 0, 8'd0, 0, 0, "t5_release");
    cyc(0, 0, 0, 1, 4'd4, 8'd0, 0, 0, "t5_after");
    cyc(0, 0, 0, 0, 0, 8'd4, 0, 0, "t5_load");
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
